// File: rtl/udp_sample_packetizer_if.sv
// Sample-stream input and UDP header/payload output bundle of udp_sample_packetizer.
// master = packetizer side, slave = sample source plus MAC side.
`timescale 1ns/1ps
interface udp_sample_packetizer_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;

  logic        tx_udp_hdr_valid;
  logic        tx_udp_hdr_ready;
  logic [31:0] tx_udp_ip_dest_ip;
  logic [15:0] tx_udp_source_port;
  logic [15:0] tx_udp_dest_port;
  logic [15:0] tx_udp_length;

  logic [7:0]  tx_udp_payload_axis_tdata;
  logic        tx_udp_payload_axis_tvalid;
  logic        tx_udp_payload_axis_tready;
  logic        tx_udp_payload_axis_tlast;
  logic        tx_udp_payload_axis_tuser;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output tx_udp_hdr_valid, tx_udp_ip_dest_ip, tx_udp_source_port,
    output tx_udp_dest_port, tx_udp_length,
    input  tx_udp_hdr_ready,
    output tx_udp_payload_axis_tdata, tx_udp_payload_axis_tvalid,
    output tx_udp_payload_axis_tlast, tx_udp_payload_axis_tuser,
    input  tx_udp_payload_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  tx_udp_hdr_valid, tx_udp_ip_dest_ip, tx_udp_source_port,
    input  tx_udp_dest_port, tx_udp_length,
    output tx_udp_hdr_ready,
    input  tx_udp_payload_axis_tdata, tx_udp_payload_axis_tvalid,
    input  tx_udp_payload_axis_tlast, tx_udp_payload_axis_tuser,
    output tx_udp_payload_axis_tready
  );
endinterface

// File: rtl/udp_sample_packetizer.sv
// Frames an 8-bit sample stream into fixed-length, zero-padded UDP datagrams.
// Define PACKETIZER_SEQ_HDR_EN to prefix every datagram with a 16-bit big-endian sequence number.
`timescale 1ns/1ps
module udp_sample_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter logic [15:0] SRC_PORT    = 16'd5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_enable,
  input  logic [31:0]              cfg_dest_ip,
  input  logic [15:0]              cfg_dest_port,
  udp_sample_packetizer_if.master  bus,
  output logic                     pkt_sent
);

  localparam int unsigned CNT_W = 11;
`ifdef PACKETIZER_SEQ_HDR_EN
  localparam int unsigned SEQ_BYTES = 2;
  typedef enum logic [2:0] {IDLE, HDR, SEQ_HI, SEQ_LO, DATA, PAD} state_e;
`else
  localparam int unsigned SEQ_BYTES = 0;
  typedef enum logic [2:0] {IDLE, HDR, DATA, PAD} state_e;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [15:0]      UDP_LEN  = 16'(8 + PAYLOAD_LEN + SEQ_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dest_ip_q, dest_ip_d;
  logic [15:0]      dest_port_q, dest_port_d;
  logic             tvalid_c, tlast_c;
  logic [7:0]       tdata_c;
  logic             s_tready_c, hdr_valid_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dest_ip_q   <= '0;
      dest_port_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_ip_q   <= dest_ip_d;
      dest_port_q <= dest_port_d;
    end
  end

`ifdef PACKETIZER_SEQ_HDR_EN
  logic [15:0] seq_q;

  // Sequence number advances once per completed datagram and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           seq_q <= '0;
    else if (pkt_sent) seq_q <= seq_q + 16'd1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dest_ip_d   = dest_ip_q;
    dest_port_d = dest_port_q;
    hdr_valid_c = 1'b0;
    tvalid_c    = 1'b0;
    tdata_c     = 8'h00;
    tlast_c     = 1'b0;
    s_tready_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable && bus.s_axis_tvalid) begin
          dest_ip_d   = cfg_dest_ip;
          dest_port_d = cfg_dest_port;
          cnt_d       = '0;
          state_d     = HDR;
        end
      end
      HDR: begin
        hdr_valid_c = 1'b1;
        if (bus.tx_udp_hdr_ready) begin
`ifdef PACKETIZER_SEQ_HDR_EN
          state_d = SEQ_HI;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef PACKETIZER_SEQ_HDR_EN
      SEQ_HI: begin
        tvalid_c = 1'b1;
        tdata_c  = seq_q[15:8];
        if (bus.tx_udp_payload_axis_tready) state_d = SEQ_LO;
      end
      SEQ_LO: begin
        tvalid_c = 1'b1;
        tdata_c  = seq_q[7:0];
        if (bus.tx_udp_payload_axis_tready) state_d = DATA;
      end
`endif
      // Zero-latency pass-through; an early tlast switches to padding.
      DATA: begin
        tvalid_c   = bus.s_axis_tvalid;
        tdata_c    = bus.s_axis_tdata;
        s_tready_c = bus.tx_udp_payload_axis_tready;
        tlast_c    = (cnt_q == LAST_IDX);
        if (bus.s_axis_tvalid && bus.tx_udp_payload_axis_tready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.s_axis_tlast) state_d = PAD;
          end
        end
      end
      PAD: begin
        tvalid_c = 1'b1;
        tlast_c  = (cnt_q == LAST_IDX);
        if (bus.tx_udp_payload_axis_tready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_axis_tready              = s_tready_c;
  assign bus.tx_udp_hdr_valid           = hdr_valid_c;
  assign bus.tx_udp_ip_dest_ip          = dest_ip_q;
  assign bus.tx_udp_dest_port           = dest_port_q;
  assign bus.tx_udp_source_port         = SRC_PORT;
  assign bus.tx_udp_length              = UDP_LEN;
  assign bus.tx_udp_payload_axis_tdata  = tdata_c;
  assign bus.tx_udp_payload_axis_tvalid = tvalid_c;
  assign bus.tx_udp_payload_axis_tlast  = tlast_c;
  assign bus.tx_udp_payload_axis_tuser  = 1'b0;
  assign pkt_sent = tvalid_c && bus.tx_udp_payload_axis_tready && tlast_c;

endmodule
